sigrnd_pipe: RTL and testbench
==============================

# sigrnd_pipe

Two-stage, valid/ready-pipelined significand rounder for the double-precision rounder path. Takes a normalized significand with guard and sticky bits from the normalize-shift stage. Applies the IEEE rounding increment and post-normalizes on carry-out. Delivers `s`, `e3`, `f3`, `RM`, `OVF` and `OVFen` directly to `exprnd`, which sits immediately downstream.

## Interface
Parameters:
- `EW`, 11, exponent width of `e3`; internal exponent is `EW+1` bits.
- `FW`, 52, stored fraction width; significand `f3` is `FW+1` bits.

Ports. Clock and reset are listed first; reset is asynchronous and active-high.
- `clk` in 1 — rising-edge clock.
- `rst` in 1 — asynchronous, active-high reset.
- `in_valid` in 1 — input beat valid.
- `in_ready` out 1 — stage can accept a beat.
- `s_in` in 1 — sign.
- `e2` in `EW+1` — biased exponent, unsigned, range 1..4094.
- `f2` in `FW+3` — bits [54:2] hold the significand 1.f (bit 54 = hidden 1), bit 1 = guard, bit 0 = sticky.
- `RM_in` in 2 — rounding mode: 00 RZ, 01 RNE, 10 R+inf, 11 R-inf.
- `OVFen_in` in 1 — overflow trap enable.
- `out_valid` out 1 — output beat valid.
- `out_ready` in 1 — downstream accepts.
- `s` out 1 — sign, to `exprnd`.
- `e3` out `EW` — rounded exponent, low `EW` bits of the internal exponent.
- `f3` out `FW+1` — rounded significand.
- `RM` out 2 — rounding mode, passed through.
- `OVF` out 1 — overflow flag.
- `OVFen` out 1 — trap enable, passed through.
- `inx` out 1 — inexact flag.

## Operation
- Stage 1 (decide):
  - Latch `s_in`, `e2`, `f2[54:2]`, `RM_in` and `OVFen_in`.
  - Compute `inx1 = guard | sticky`.
  - Compute the increment `inc`:
    - RZ: 0.
    - RNE: `guard & (sticky | f2[2])`.
    - R+inf: `inx1 & ~s_in`.
    - R-inf: `inx1 & s_in`.
  - Register `inc` and `inx1`.
- Stage 2 (add / post-normalize):
  - `sum = {1'b0, sig} + inc`, which is `FW+2` bits.
  - If `sum[FW+1]` is set: `f3 = sum[FW+1:1]` (= 1.000…0) and `e_post = e + 1`.
  - Otherwise: `f3 = sum[FW:0]` and `e_post = e`.
  - `OVF = (e_post >= 2047)`.
  - `e3 = e_post[EW-1:0]`; `exprnd` resolves the OVF encoding.
  - `inx = inx1`.
  - All outputs are registered.
- Handshake:
  - A beat transfers on `valid & ready` at a rising edge.
  - `in_ready = ~v1 | ~v2 | out_ready`, where `v1`/`v2` are the stage-valid bits.
  - Stage 2 loads from stage 1 when `v1 & (~v2 | out_ready)`.
  - Stage 1 loads from the input when `in_valid & in_ready`.
  - When `out_valid & ~out_ready`, outputs hold stable.
  - No beat is dropped or duplicated.
- Bubbles: stage valid bits clear independently when a stage drains. Data registers need no clear.

## Timing
- Latency: 2 cycles from input acceptance to `out_valid`, with no backpressure.
- Throughput: 1 beat/cycle while `out_ready` = 1.
- Reset values:
  - `v1 = v2 = 0`, so `out_valid = 0`.
  - `in_ready = 1`.
  - `s`, `e3`, `f3`, `RM`, `OVF`, `OVFen`, `inx` = 0.
- Reset mid-operation: all in-flight beats are discarded. On the first edge after `rst` falls, `in_ready` is 1 and `out_valid` is 0.
- Backpressure:
  - Full pipe (`v1 = v2 = 1`) with `out_ready = 0` gives `in_ready = 0`.
  - Simultaneous drain and fill in the same cycle is legal and is required to sustain full rate.
- `in_ready` is combinational from `out_ready`. No other combinational input-to-output path is permitted.
- Boundaries:
  - All-ones significand with `inc = 1` carries out: `f3 = 1.0`, exponent +1.
  - `e2 = 2046` with carry-out gives `OVF = 1` and `e3 = 11'h7FF`.
  - `e2 ≥ 2047` gives `OVF = 1` regardless of rounding.

## Structure
- Shared package `fpu_pkg` holds:
  - The `rm_t` enum (`RM_RZ`, `RM_RNE`, `RM_RPI`, `RM_RMI`).
  - `EW`/`FW` constants.
  - `EMAX_BIASED = 2047`.
  - A `rnd_beat_t` struct {s, e, sig, rm, ovfen}.
- One natural sub-module: `rnd_inc`, the combinational increment decision (sign, RM, lsb, guard, sticky → inc, inx). It is reused by the single-precision rounder.

## Test plan
1. RNE tie-to-even:
   - `s_in = 0`, `e2 = 1023`, `sig = 1.0…0` (lsb 0), `guard = 1`, `sticky = 0`, `RM = 01` → after 2 cycles `f3 = 1.0…0`, `e3 = 1023`, `inx = 1`, `OVF = 0`.
   - Same beat with lsb 1 → `f3` lsb position increments, i.e. `f3 = sig + 1`.
2. Directed rounding:
   - `s_in = 1`, `guard = 0`, `sticky = 1`, `RM = 11` → `inc` applied, `f3 = sig + 1`.
   - Same beat with `RM = 10` → `f3 = sig`, `inx = 1`.
3. Carry-out overflow:
   - `e2 = 2046`, all-ones significand, `guard = 1`, `RM = 01` → `f3 = 53'h10000000000000`, `e3 = 11'h7FF`, `OVF = 1`, `OVFen` passed through.
4. Backpressure:
   - Stream 4 beats with `out_ready = 0` → `in_ready` drops after 2 accepted beats.
   - Release `out_ready` → all 4 beats emerge in order, unaltered, one per cycle.
5. Reset mid-stream:
   - Assert `rst` asynchronously with `v1 = v2 = 1` → `out_valid` = 0 immediately, all outputs 0.
   - After release, the next beat has 2-cycle latency.
6. Exact input:
   - `guard = sticky = 0`, any RM → `f3 = sig`, `inx = 0`.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, format widths and the rounder beat record.
package fpu_pkg;

  localparam int unsigned EW          = 11;
  localparam int unsigned FW          = 52;
  localparam int unsigned EMAX_BIASED = 2047;

  typedef enum logic [1:0] {
    RM_RZ  = 2'b00,
    RM_RNE = 2'b01,
    RM_RPI = 2'b10,
    RM_RMI = 2'b11
  } rm_t;

  typedef struct packed {
    logic          s;
    logic [EW:0]   e;
    logic [FW:0]   sig;
    rm_t           rm;
    logic          ovfen;
  } rnd_beat_t;

endpackage

// File: rtl/rnd_inc.sv
// IEEE rounding increment decision; format independent, shared with the single-precision rounder.
module rnd_inc
  import fpu_pkg::*;
(
  input  logic s,
  input  rm_t  rm,
  input  logic lsb,
  input  logic guard,
  input  logic sticky,
  output logic inc,
  output logic inx
);

  always_comb begin
    inc = 1'b0;
    inx = guard | sticky;
    unique case (rm)
      RM_RZ:   inc = 1'b0;
      RM_RNE:  inc = guard & (sticky | lsb);
      RM_RPI:  inc = inx & ~s;
      RM_RMI:  inc = inx & s;
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/sigrnd_pipe.sv
// Two-stage valid/ready significand rounder: stage 1 decides the increment, stage 2 adds and
// post-normalizes. Feeds exprnd directly.
module sigrnd_pipe #(
  parameter int unsigned EW = fpu_pkg::EW,
  parameter int unsigned FW = fpu_pkg::FW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          s_in,
  input  logic [EW:0]   e2,
  input  logic [FW+2:0] f2,
  input  logic [1:0]    RM_in,
  input  logic          OVFen_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          s,
  output logic [EW-1:0] e3,
  output logic [FW:0]   f3,
  output logic [1:0]    RM,
  output logic          OVF,
  output logic          OVFen,
  output logic          inx
);

  import fpu_pkg::rm_t;
  import fpu_pkg::rnd_beat_t;
  import fpu_pkg::EMAX_BIASED;

  localparam logic [EW:0] EMaxE = (EW+1)'(EMAX_BIASED);

  logic      v1_q, v1_d, v2_q, v2_d;
  logic      ld1, ld2;
  rnd_beat_t b1_q;
  logic      inc1_q, inx1_q;
  logic      inc_c, inx_c;

  logic [FW+1:0] sum;
  logic [FW:0]   f_post;
  logic [EW:0]   e_post;

  rnd_inc u_rnd_inc (
    .s      (s_in),
    .rm     (rm_t'(RM_in)),
    .lsb    (f2[2]),
    .guard  (f2[1]),
    .sticky (f2[0]),
    .inc    (inc_c),
    .inx    (inx_c)
  );

  // Full pipe can still accept when the output drains this cycle.
  assign in_ready  = ~v1_q | ~v2_q | out_ready;
  assign out_valid = v2_q;
  assign ld1       = in_valid & in_ready;
  assign ld2       = v1_q & (~v2_q | out_ready);

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    if (ld1)            v1_d = 1'b1;
    else if (ld2)       v1_d = 1'b0;
    if (ld2)            v2_d = 1'b1;
    else if (out_ready) v2_d = 1'b0;
  end

  always_comb begin
    sum    = {1'b0, b1_q.sig} + {{(FW+1){1'b0}}, inc1_q};
    f_post = sum[FW:0];
    e_post = b1_q.e;
    if (sum[FW+1]) begin
      f_post = sum[FW+1:1];
      e_post = b1_q.e + {{EW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      b1_q   <= '0;
      inc1_q <= 1'b0;
      inx1_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      if (ld1) begin
        b1_q.s     <= s_in;
        b1_q.e     <= e2;
        b1_q.sig   <= f2[FW+2:2];
        b1_q.rm    <= rm_t'(RM_in);
        b1_q.ovfen <= OVFen_in;
        inc1_q     <= inc_c;
        inx1_q     <= inx_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q  <= 1'b0;
      s     <= 1'b0;
      e3    <= '0;
      f3    <= '0;
      RM    <= '0;
      OVF   <= 1'b0;
      OVFen <= 1'b0;
      inx   <= 1'b0;
    end else begin
      v2_q <= v2_d;
      if (ld2) begin
        s     <= b1_q.s;
        e3    <= e_post[EW-1:0];
        f3    <= f_post;
        RM    <= b1_q.rm;
        OVF   <= (e_post >= EMaxE);
        OVFen <= b1_q.ovfen;
        inx   <= inx1_q;
      end
    end
  end

endmodule

// File: tb/tb_sigrnd_pipe.sv
// Directed bench for sigrnd_pipe: vector table plus backpressure and mid-stream reset sequences.
module tb_sigrnd_pipe;

  localparam logic [52:0] ONE  = 53'h10000000000000;
  localparam logic [52:0] ALL1 = 53'h1FFFFFFFFFFFFF;
  localparam logic [52:0] MIX  = 53'h1ABCDEF0123456;
  localparam int          NVEC = 17;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, s_in, OVFen_in, out_valid, out_ready;
  logic [11:0] e2;
  logic [54:0] f2;
  logic [1:0]  RM_in, RM;
  logic        s, OVF, OVFen, inx;
  logic [10:0] e3;
  logic [52:0] f3;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic        s;
    logic [11:0] e;
    logic [52:0] sig;
    logic        g;
    logic        st;
    logic [1:0]  rm;
    logic        ovfen;
    logic [52:0] xf3;
    logic [10:0] xe3;
    logic        xovf;
    logic        xinx;
  } vec_t;

  vec_t vecs [NVEC];

  sigrnd_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_in      (s_in),
    .e2        (e2),
    .f2        (f2),
    .RM_in     (RM_in),
    .OVFen_in  (OVFen_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .e3        (e3),
    .f3        (f3),
    .RM        (RM),
    .OVF       (OVF),
    .OVFen     (OVFen),
    .inx       (inx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    s_in     = v.s;
    e2       = v.e;
    f2       = {v.sig, v.g, v.st};
    RM_in    = v.rm;
    OVFen_in = v.ovfen;
    in_valid = 1'b1;
  endtask

  task automatic check_out(input string tag, input vec_t v);
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_f3"}, f3, v.xf3);
    check({tag, "_e3"}, e3, v.xe3);
    check({tag, "_ovf"}, OVF, v.xovf);
    check({tag, "_inx"}, inx, v.xinx);
    check({tag, "_s"}, s, v.s);
    check({tag, "_rm"}, RM, v.rm);
    check({tag, "_ovfen"}, OVFen, v.ovfen);
  endtask

  // One beat through an otherwise idle pipe, checking exact 2-cycle latency.
  task automatic run_vec(input int i);
    string tag;
    tag = $sformatf("v%0d", i);
    @(negedge clk);
    out_ready = 1'b1;
    drive(vecs[i]);
    #1 check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check({tag, "_lat1_valid"}, out_valid, 0);
    @(negedge clk);
    #1 check_out(tag, vecs[i]);
  endtask

  task automatic bp_test();
    int   acc, nout, first_fire, last_fire;
    logic acc_now;
    acc = 0; nout = 0; first_fire = -1; last_fire = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 6);
      if (acc < 4) drive(vecs[acc]);
      else in_valid = 1'b0;
      #1;
      if (cyc == 3) begin
        check("bp_in_ready_low", in_ready, 0);
        check("bp_full_valid", out_valid, 1);
      end
      if (cyc == 5) check("bp_hold_f3", f3, vecs[0].xf3);
      acc_now = in_valid & in_ready;
      if (out_valid && out_ready) begin
        if (nout < 4) begin
          check($sformatf("bp_order%0d_f3", nout), f3, vecs[nout].xf3);
          check($sformatf("bp_order%0d_e3", nout), e3, vecs[nout].xe3);
        end else begin
          check("bp_extra_beat", nout, 3);
        end
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
        nout++;
      end
      @(posedge clk);
      if (acc_now) acc++;
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, 4);
    check("bp_emitted", nout, 4);
    check("bp_first_fire", first_fire, 6);
    check("bp_rate", last_fire - first_fire, 3);
  endtask

  initial begin
    //           s     e        sig       g     st    rm     ovfen xf3       xe3        ovf   inx
    vecs[0]  = '{1'b0, 12'd1023, ONE,     1'b1, 1'b0, 2'b01, 1'b0, ONE,      11'd1023,  1'b0, 1'b1};
    vecs[1]  = '{1'b0, 12'd1023, ONE + 1, 1'b1, 1'b0, 2'b01, 1'b0, ONE + 2,  11'd1023,  1'b0, 1'b1};
    vecs[2]  = '{1'b1, 12'd1000, ONE + 5, 1'b0, 1'b1, 2'b11, 1'b0, ONE + 6,  11'd1000,  1'b0, 1'b1};
    vecs[3]  = '{1'b1, 12'd1000, ONE + 5, 1'b0, 1'b1, 2'b10, 1'b1, ONE + 5,  11'd1000,  1'b0, 1'b1};
    vecs[4]  = '{1'b0, 12'd2046, ALL1,    1'b1, 1'b0, 2'b01, 1'b1, ONE,      11'h7FF,   1'b1, 1'b1};
    vecs[5]  = '{1'b0, 12'd500,  MIX,     1'b0, 1'b0, 2'b01, 1'b0, MIX,      11'd500,   1'b0, 1'b0};
    vecs[6]  = '{1'b1, 12'd500,  MIX,     1'b0, 1'b0, 2'b11, 1'b0, MIX,      11'd500,   1'b0, 1'b0};
    vecs[7]  = '{1'b0, 12'd700,  ONE + 3, 1'b1, 1'b1, 2'b00, 1'b0, ONE + 3,  11'd700,   1'b0, 1'b1};
    vecs[8]  = '{1'b0, 12'd3000, ONE,     1'b0, 1'b0, 2'b00, 1'b1, ONE,      11'd952,   1'b1, 1'b0};
    vecs[9]  = '{1'b0, 12'd10,   ONE,     1'b0, 1'b1, 2'b10, 1'b0, ONE + 1,  11'd10,    1'b0, 1'b1};
    vecs[10] = '{1'b0, 12'd10,   ONE,     1'b0, 1'b1, 2'b01, 1'b0, ONE,      11'd10,    1'b0, 1'b1};
    vecs[11] = '{1'b1, 12'd10,   ONE + 2, 1'b1, 1'b1, 2'b01, 1'b0, ONE + 3,  11'd10,    1'b0, 1'b1};
    vecs[12] = '{1'b0, 12'd2047, ONE,     1'b0, 1'b0, 2'b00, 1'b0, ONE,      11'h7FF,   1'b1, 1'b0};
    vecs[13] = '{1'b1, 12'd100,  ALL1,    1'b1, 1'b0, 2'b11, 1'b0, ONE,      11'd101,   1'b0, 1'b1};
    vecs[14] = '{1'b0, 12'd100,  ALL1,    1'b1, 1'b0, 2'b10, 1'b0, ONE,      11'd101,   1'b0, 1'b1};
    vecs[15] = '{1'b1, 12'd100,  ALL1,    1'b1, 1'b1, 2'b10, 1'b0, ALL1,     11'd100,   1'b0, 1'b1};
    vecs[16] = '{1'b0, 12'd2046, ALL1,    1'b1, 1'b0, 2'b00, 1'b0, ALL1,     11'h7FE,   1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    s_in = 1'b0; e2 = '0; f2 = '0; RM_in = '0; OVFen_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_f3", f3, 0);
    check("rst_e3", e3, 0);
    check("rst_ovf", OVF, 0);
    check("rst_inx", inx, 0);
    check("rst_s_rm_ovfen", {s, RM, OVFen}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vec(i);

    bp_test();

    // Fill both stages under backpressure, then reset asynchronously mid-cycle.
    @(negedge clk);
    out_ready = 1'b0;
    drive(vecs[2]);
    @(negedge clk);
    drive(vecs[3]);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("mrst_full_in_ready", in_ready, 0);
    check("mrst_full_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_f3", f3, 0);
    check("mrst_e3", e3, 0);
    check("mrst_flags", {s, RM, OVF, OVFen, inx}, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    run_vec(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
